turfio_sync_count_multi: RTL and testbench
==========================================

# turfio_sync_count_multi

Parametrised successor to the TURFIO SYSCLK sync/counter block. It delays a sync request by a programmable number of cycles, then realigns a phase counter and a wide SYSCLK counter. It drives NSYNC independently armed external SYNC outputs, each of which re-syncs only once per enable. It adds a timestamp capture port and a SURF-clock mimic generalised to any phase period.

## Interface
Parameters:
- NSYNC, 2: number of external SYNC outputs/channels.
- PHASE_BITS, 4: phase counter width; period P = 2^PHASE_BITS.
- COUNT_WIDTH, 48: SYSCLK counter width.
- OFFSET_WIDTH, 8: width of clock_offset_i (≤ COUNT_WIDTH).
- DELAY_BITS, 5: sync delay select width; max delay 2^DELAY_BITS.
- RAISE_PHASE, 11: phase in which a lowered SYNC output reads high again (2 ≤ RAISE_PHASE ≤ P-1).

Ports:
- sysclk_i, in, 1: system clock; sole clock.
- rst_i, in, 1: reset, asynchronous, active-high.
- sync_req_i, in, 1: sync request, sysclk domain.
- sync_delay_i, in, DELAY_BITS: delay select, quasi-static.
- clock_offset_i, in, OFFSET_WIDTH: counter load value, quasi-static.
- en_ext_sync_i, in, NSYNC: per-channel arm enables, asynchronous.
- capture_i, in, 1: timestamp capture strobe.
- sysclk_count_o, out, COUNT_WIDTH: free-running counter.
- phase_o, out, PHASE_BITS: current phase.
- sync_o, out, 1: phase-wrap flag.
- capture_count_o, out, COUNT_WIDTH: captured counter value.
- capture_valid_o, out, 1: capture strobe.
- sync_armed_o, out, NSYNC: channel enabled and not yet synced.
- dbg_surf_clk_o, out, 1: SURF clock mimic.
- SYNC, out, NSYNC: external sync outputs. IOB registers.

## Operation
- Config resync: sync_delay_i and clock_offset_i each get one register stage. en_ext_sync_i gets a 2-FF synchroniser per bit (en_s).
- Delay line: shift register, depth 2^DELAY_BITS. Tap select is the resynced delay. do_sync is high in the cycle after sync_req_i has been sampled high on sync_delay+1 edges.
- Phase counter, PHASE_BITS+1 bits:
  - do_sync loads 0.
  - Otherwise the counter becomes low PHASE_BITS bits + 1.
  - phase_o = low bits.
  - sync_o = top bit. It is high for one cycle after each natural wrap P-1→0, and never after a do_sync load.
- SYSCLK counter:
  - do_sync loads zero-extended clock_offset.
  - Otherwise it increments modulo 2^COUNT_WIDTH.
- Per channel k:
  - done[k] clears while en_s[k]=0. It sets on do_sync when en_s[k]=1.
  - SYNC[k] is lowered on do_sync && en_s[k] && !done[k].
  - Otherwise SYNC[k] is raised when raise_q=1.
  - raise_q <= (phase==RAISE_PHASE-2) && !do_sync. A do_sync that coincides with the raise-setup phase suppresses the raise.
  - Lowering has priority over raising.
  - sync_armed_o[k] = en_s[k] && !done[k].
- Capture: capture_i high at edge t gives capture_count_o = sysclk_count_o value at t and capture_valid_o=1 for one cycle at t+1. Back-to-back strobes capture every cycle.
- SURF mimic: set when phase==P-1, clear when phase==P/2-1. It is high for phases 0..P/2-1.
- Reset (rst_i=1, any time):
  - Counters, phase, delay line, done, en_s, raise_q, capture outputs and dbg_surf_clk_o all go to 0.
  - SYNC goes to all ones.
  - Outputs take these values immediately. Normal operation resumes on the first edge after deassertion. A pending delayed request is discarded.

## Timing
- do_sync at cycle T:
  - At T+1: phase_o=0, sysclk_count_o=offset, armed SYNC[k]=0, done[k]=1.
  - SYNC[k] stays 0 through phase RAISE_PHASE-1 and reads 1 in the cycle phase_o==RAISE_PHASE (T+1+RAISE_PHASE).
- With default P=16 and RAISE_PHASE=11, SYNC is low for 11 cycles.
- Request-to-load latency is sync_delay+2 edges.
- Repeated do_sync with done[k]=1 re-aligns the counters but leaves SYNC[k] high.
- A second do_sync inside the low window restarts the phase and delays the raise accordingly.
- Counter wrap 2^COUNT_WIDTH-1→0 is silent.

## Test plan
- Reset mid-operation: with rst_i asserted while SYNC=0 and the counter ≠ 0, outputs go to SYNC all ones, counter 0, phase 0 and capture_valid_o 0 before the next edge.
- Latency: delay=3, offset=0x20, en=2'b01, sync_req_i pulse at cycle 0 gives phase_o=0 and count 0x20 at cycle 5. SYNC[0] is low on cycles 5–15 and high on cycle 16. SYNC[1] stays 1 throughout.
- One-shot: a second request with en still high re-loads the counter with no SYNC low pulse. Dropping en for 3+ cycles, re-raising it, then requesting again produces one low pulse.
- Wrap flag: sync_o pulses with phase_o=0 every 16 cycles and never after a do_sync load. dbg_surf_clk_o is high for phases 0–7.
- Edge coincidence: do_sync landing in phase 9 produces no spurious raise at the next cycle. SYNC rises at phase 11 of the new alignment.
- Capture: capture_i pulses on two consecutive cycles at count N give capture_count_o = N then N+1, each with a 1-cycle capture_valid_o.

Source files
------------

// File: rtl/turfio_sync_count_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : turfio_sync_count_multi_if
// Brief    : Request, configuration and status bundle for the sync/counter block.
// Revision : 1.0 - initial release
// ============================================================================
interface turfio_sync_count_multi_if #(
  parameter int NSYNC        = 2,
  parameter int PHASE_BITS   = 4,
  parameter int COUNT_WIDTH  = 48,
  parameter int OFFSET_WIDTH = 8,
  parameter int DELAY_BITS   = 5
);
  logic                    sync_req_i;
  logic [DELAY_BITS-1:0]   sync_delay_i;
  logic [OFFSET_WIDTH-1:0] clock_offset_i;
  logic [NSYNC-1:0]        en_ext_sync_i;
  logic                    capture_i;
  logic [COUNT_WIDTH-1:0]  sysclk_count_o;
  logic [PHASE_BITS-1:0]   phase_o;
  logic                    sync_o;
  logic [COUNT_WIDTH-1:0]  capture_count_o;
  logic                    capture_valid_o;
  logic [NSYNC-1:0]        sync_armed_o;
  logic                    dbg_surf_clk_o;
  logic [NSYNC-1:0]        SYNC;

  modport master (
    output sync_req_i, sync_delay_i, clock_offset_i, en_ext_sync_i, capture_i,
    input  sysclk_count_o, phase_o, sync_o, capture_count_o, capture_valid_o,
    input  sync_armed_o, dbg_surf_clk_o, SYNC
  );

  modport slave (
    input  sync_req_i, sync_delay_i, clock_offset_i, en_ext_sync_i, capture_i,
    output sysclk_count_o, phase_o, sync_o, capture_count_o, capture_valid_o,
    output sync_armed_o, dbg_surf_clk_o, SYNC
  );
endinterface
`default_nettype wire

// File: rtl/turfio_sync_count_multi.sv
`default_nettype none
// ============================================================================
// Module   : turfio_sync_count_multi
// Brief    : Delayed sync realignment of phase/SYSCLK counters, one-shot SYNC
//            outputs per channel, timestamp capture and SURF clock mimic.
// Revision : 1.0 - initial release
// ============================================================================
module turfio_sync_count_multi #(
  parameter int NSYNC        = 2,
  parameter int PHASE_BITS   = 4,
  parameter int COUNT_WIDTH  = 48,
  parameter int OFFSET_WIDTH = 8,
  parameter int DELAY_BITS   = 5,
  parameter int RAISE_PHASE  = 11
) (
  input  wire logic                sysclk_i,
  input  wire logic                rst_i,
  turfio_sync_count_multi_if.slave bus
);

  localparam int                    c_period      = 2 ** PHASE_BITS;
  localparam int                    c_depth       = 2 ** DELAY_BITS;
  localparam logic [PHASE_BITS-1:0] c_raise_setup = PHASE_BITS'(RAISE_PHASE - 2);
  localparam logic [PHASE_BITS-1:0] c_phase_last  = PHASE_BITS'(c_period - 1);
  localparam logic [PHASE_BITS-1:0] c_phase_half  = PHASE_BITS'(c_period / 2 - 1);

  // configuration and enable resynchronisation
  logic [DELAY_BITS-1:0]   r_sync_delay;
  logic [OFFSET_WIDTH-1:0] r_clock_offset;
  logic [NSYNC-1:0]        r_en_meta;
  logic [NSYNC-1:0]        r_en_s;

  // request delay line
  logic [c_depth-1:0]      r_dly;
  logic                    w_do_sync;

  // counters
  logic [PHASE_BITS:0]     r_phase_cnt;
  logic [PHASE_BITS:0]     w_phase_cnt_nxt;
  logic [PHASE_BITS-1:0]   w_phase;
  logic [COUNT_WIDTH-1:0]  r_count;
  logic [COUNT_WIDTH-1:0]  w_count_nxt;

  // SYNC channels
  logic [NSYNC-1:0]        r_done;
  logic [NSYNC-1:0]        w_done_nxt;
  (* IOB = "TRUE" *)
  logic [NSYNC-1:0]        r_sync;
  logic [NSYNC-1:0]        w_sync_nxt;
  logic                    r_raise;
  logic                    w_raise_nxt;

  // capture and SURF mimic
  logic [COUNT_WIDTH-1:0]  r_cap_count;
  logic [COUNT_WIDTH-1:0]  w_cap_count_nxt;
  logic                    r_cap_valid;
  logic                    r_surf;
  logic                    w_surf_nxt;

  assign w_phase   = r_phase_cnt[PHASE_BITS-1:0];
  assign w_do_sync = r_dly[r_sync_delay];

  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync_delay   <= '0;
      r_clock_offset <= '0;
      r_en_meta      <= '0;
      r_en_s         <= '0;
      r_dly          <= '0;
    end else begin
      r_sync_delay   <= bus.sync_delay_i;
      r_clock_offset <= bus.clock_offset_i;
      r_en_meta      <= bus.en_ext_sync_i;
      r_en_s         <= r_en_meta;
      r_dly          <= {r_dly[c_depth-2:0], bus.sync_req_i};
    end
  end

  // A load clears the wrap bit, so sync_o only follows natural wraps.
  always_comb begin
    w_phase_cnt_nxt = {1'b0, w_phase} + (PHASE_BITS + 1)'(1);
    w_count_nxt     = r_count + COUNT_WIDTH'(1);
    if (w_do_sync) begin
      w_phase_cnt_nxt = '0;
      w_count_nxt     = COUNT_WIDTH'(r_clock_offset);
    end
  end

  always_comb begin
    w_raise_nxt     = (w_phase == c_raise_setup) && !w_do_sync;
    w_cap_count_nxt = bus.capture_i ? r_count : r_cap_count;
    w_surf_nxt      = r_surf;
    if (w_phase == c_phase_last) begin
      w_surf_nxt = 1'b1;
    end else if (w_phase == c_phase_half) begin
      w_surf_nxt = 1'b0;
    end
  end

  // Lowering wins over the pending raise; done only holds while enabled.
  for (genvar k = 0; k < NSYNC; k++) begin : g_channel
    logic w_lower;
    assign w_lower       = w_do_sync && r_en_s[k] && !r_done[k];
    assign w_sync_nxt[k] = w_lower ? 1'b0 : (r_raise ? 1'b1 : r_sync[k]);
    assign w_done_nxt[k] = r_en_s[k] && (w_do_sync || r_done[k]);
  end

  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      r_phase_cnt <= '0;
      r_count     <= '0;
      r_done      <= '0;
      r_sync      <= '1;
      r_raise     <= 1'b0;
      r_cap_count <= '0;
      r_cap_valid <= 1'b0;
      r_surf      <= 1'b0;
    end else begin
      r_phase_cnt <= w_phase_cnt_nxt;
      r_count     <= w_count_nxt;
      r_done      <= w_done_nxt;
      r_sync      <= w_sync_nxt;
      r_raise     <= w_raise_nxt;
      r_cap_count <= w_cap_count_nxt;
      r_cap_valid <= bus.capture_i;
      r_surf      <= w_surf_nxt;
    end
  end

  assign bus.sysclk_count_o  = r_count;
  assign bus.phase_o         = w_phase;
  assign bus.sync_o          = r_phase_cnt[PHASE_BITS];
  assign bus.capture_count_o = r_cap_count;
  assign bus.capture_valid_o = r_cap_valid;
  assign bus.sync_armed_o    = r_en_s & ~r_done;
  assign bus.dbg_surf_clk_o  = r_surf;
  assign bus.SYNC            = r_sync;

endmodule
`default_nettype wire

// File: tb/tb_turfio_sync_count_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_turfio_sync_count_multi
// Brief    : Self-checking bench with a cycle-indexed behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_turfio_sync_count_multi;
  localparam int NSYNC        = 2;
  localparam int PHASE_BITS   = 4;
  localparam int COUNT_WIDTH  = 48;
  localparam int OFFSET_WIDTH = 8;
  localparam int DELAY_BITS   = 5;
  localparam int RAISE_PHASE  = 11;
  localparam int P            = 2 ** PHASE_BITS;
  localparam longint MASK     = (64'd1 << COUNT_WIDTH) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  turfio_sync_count_multi_if #(
    .NSYNC(NSYNC), .PHASE_BITS(PHASE_BITS), .COUNT_WIDTH(COUNT_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH), .DELAY_BITS(DELAY_BITS)
  ) bus ();

  turfio_sync_count_multi #(
    .NSYNC(NSYNC), .PHASE_BITS(PHASE_BITS), .COUNT_WIDTH(COUNT_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH), .DELAY_BITS(DELAY_BITS), .RAISE_PHASE(RAISE_PHASE)
  ) dut (
    .sysclk_i (clk),
    .rst_i    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: phase/count are arithmetic from the last alignment point;
  // request history indexed by age gives the delayed sync.
  bit         reqh [32];
  int         dly_r;
  longint     off_r;
  bit [1:0]   en_d1, en_d2, m_done, m_sync;
  bit         m_raise, m_surf, m_capv;
  longint     m_capc;
  longint     base_cycle, base_count;

  always @(negedge clk) begin
    longint   d, ph, cnt;
    bit       ds, wrap;
    bit [1:0] ens;
    if (rst) begin
      chk("rst_count", bus.sysclk_count_o, 0);
      chk("rst_phase", bus.phase_o, 0);
      chk("rst_sync_o", bus.sync_o, 0);
      chk("rst_SYNC", bus.SYNC, 2'b11);
      chk("rst_armed", bus.sync_armed_o, 0);
      chk("rst_capv", bus.capture_valid_o, 0);
      chk("rst_capc", bus.capture_count_o, 0);
      chk("rst_surf", bus.dbg_surf_clk_o, 0);
      for (int j = 0; j < 32; j++) reqh[j] = 1'b0;
      dly_r = 0; off_r = 0; en_d1 = 0; en_d2 = 0; m_done = 0; m_sync = 2'b11;
      m_raise = 0; m_surf = 0; m_capv = 0; m_capc = 0;
      base_cycle = cyc + 1; base_count = 0;
    end else begin
      d    = cyc - base_cycle;
      ph   = d % P;
      cnt  = (base_count + d) & MASK;
      wrap = (ph == 0) && (d != 0);
      ens  = en_d2;
      chk("count", bus.sysclk_count_o, cnt);
      chk("phase", bus.phase_o, ph);
      chk("sync_o", bus.sync_o, wrap);
      chk("SYNC", bus.SYNC, m_sync);
      chk("armed", bus.sync_armed_o, ens & ~m_done);
      chk("capv", bus.capture_valid_o, m_capv);
      chk("capc", bus.capture_count_o, m_capc);
      chk("surf", bus.dbg_surf_clk_o, m_surf);
      // advance to the next cycle
      ds = reqh[dly_r];
      for (int k = 0; k < NSYNC; k++) begin
        if (ds && ens[k] && !m_done[k]) m_sync[k] = 1'b0;
        else if (m_raise)               m_sync[k] = 1'b1;
        m_done[k] = ens[k] && (ds || m_done[k]);
      end
      m_raise = (ph == RAISE_PHASE - 2) && !ds;
      if (ph == P - 1)          m_surf = 1'b1;
      else if (ph == P / 2 - 1) m_surf = 1'b0;
      m_capv = bus.capture_i;
      if (bus.capture_i) m_capc = cnt;
      if (ds) begin
        base_cycle = cyc + 1;
        base_count = off_r;
      end
      en_d2 = en_d1;
      en_d1 = bus.en_ext_sync_i;
      off_r = longint'(bus.clock_offset_i);
      dly_r = int'(bus.sync_delay_i);
      for (int j = 31; j > 0; j--) reqh[j] = reqh[j-1];
      reqh[0] = bus.sync_req_i;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rearm();
    bus.en_ext_sync_i = 2'b00;
    repeat (4) tick();
    bus.en_ext_sync_i = 2'b01;
    repeat (3) tick();
    #2;
    chk("rearm_armed", bus.sync_armed_o, 2'b01);
  endtask

  initial begin
    bus.sync_req_i     = 1'b0;
    bus.sync_delay_i   = '0;
    bus.clock_offset_i = '0;
    bus.en_ext_sync_i  = '0;
    bus.capture_i      = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("init_SYNC", bus.SYNC, 2'b11);
    chk("init_count", bus.sysclk_count_o, 0);
    repeat (3) tick();
    rst = 1'b0;

    // free-running wrap flag and SURF mimic
    #2;
    chk("wrap_start_flag", bus.sync_o, 0);
    for (int k = 1; k <= 24; k++) begin
      tick();
      #2;
      if (k == 16) begin
        chk("wrap_phase", bus.phase_o, 0);
        chk("wrap_flag", bus.sync_o, 1);
        chk("surf_p0", bus.dbg_surf_clk_o, 1);
      end
      if (k == 23) chk("surf_p7", bus.dbg_surf_clk_o, 1);
      if (k == 24) chk("surf_p8", bus.dbg_surf_clk_o, 0);
    end

    // latency: delay 3, offset 0x20, channel 0 armed
    bus.sync_delay_i   = 5'd3;
    bus.clock_offset_i = 8'h20;
    bus.en_ext_sync_i  = 2'b01;
    repeat (4) tick();
    bus.sync_req_i = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      tick();
      bus.sync_req_i = 1'b0;
      #2;
      if (n == 1) chk("lat_armed_before", bus.sync_armed_o, 2'b01);
      if (n == 4) chk("lat_pre_SYNC", bus.SYNC, 2'b11);
      if (n == 5) begin
        chk("lat_phase", bus.phase_o, 0);
        chk("lat_count", bus.sysclk_count_o, 48'h20);
        chk("lat_armed_after", bus.sync_armed_o, 0);
        chk("lat_no_wrap", bus.sync_o, 0);
      end
      if (n >= 5 && n <= 15) chk("lat_sync0_low", bus.SYNC[0], 0);
      if (n == 16) begin
        chk("lat_sync0_high", bus.SYNC[0], 1);
        chk("lat_raise_phase", bus.phase_o, RAISE_PHASE);
      end
      chk("lat_sync1_idle", bus.SYNC[1], 1);
    end

    // one-shot: re-request while still enabled, with back-to-back capture
    bus.clock_offset_i = 8'h40;
    repeat (3) tick();
    bus.sync_req_i = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      bus.sync_req_i = 1'b0;
      bus.capture_i  = (n == 8) || (n == 9);
      #2;
      if (n == 5) chk("oneshot_count", bus.sysclk_count_o, 48'h40);
      if (n >= 5) chk("oneshot_SYNC_high", bus.SYNC, 2'b11);
      if (n == 9) begin
        chk("cap1_valid", bus.capture_valid_o, 1);
        chk("cap1_count", bus.capture_count_o, 48'h43);
      end
      if (n == 10) begin
        chk("cap2_valid", bus.capture_valid_o, 1);
        chk("cap2_count", bus.capture_count_o, 48'h44);
      end
      if (n == 11) chk("cap_valid_drop", bus.capture_valid_o, 0);
    end

    // re-arm then request: exactly one low pulse
    rearm();
    bus.sync_req_i = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      bus.sync_req_i = 1'b0;
      #2;
      if (n == 5)  chk("rearm_sync0_low", bus.SYNC[0], 0);
      if (n == 16) chk("rearm_sync0_high", bus.SYNC[0], 1);
    end

    // second sync landing in the raise-setup phase of the low window
    rearm();
    bus.sync_req_i = 1'b1;
    for (int n = 1; n <= 27; n++) begin
      tick();
      bus.sync_req_i = (n == 10);
      #2;
      if (n == 14) chk("coinc_phase9", bus.phase_o, RAISE_PHASE - 2);
      if (n == 15) chk("coinc_realign", bus.phase_o, 0);
      if (n >= 5 && n <= 25) chk("coinc_sync0_low", bus.SYNC[0], 0);
      if (n == 26) begin
        chk("coinc_sync0_high", bus.SYNC[0], 1);
        chk("coinc_rise_phase", bus.phase_o, RAISE_PHASE);
      end
    end

    // asynchronous reset in the middle of a low window
    rearm();
    bus.sync_req_i = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      bus.sync_req_i = 1'b0;
      bus.capture_i  = (n == 7);
    end
    bus.capture_i = 1'b0;
    #2;
    chk("midrst_pre_low", bus.SYNC[0], 0);
    chk("midrst_pre_capv", bus.capture_valid_o, 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_SYNC", bus.SYNC, 2'b11);
    chk("midrst_count", bus.sysclk_count_o, 0);
    chk("midrst_phase", bus.phase_o, 0);
    chk("midrst_capv", bus.capture_valid_o, 0);
    tick();
    tick();
    rst = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      bus.sync_req_i = ($urandom_range(0, 24) == 0);
      bus.capture_i  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0)  bus.en_ext_sync_i  = NSYNC'($urandom);
      if ($urandom_range(0, 149) == 0) bus.sync_delay_i   = DELAY_BITS'($urandom);
      if ($urandom_range(0, 99) == 0)  bus.clock_offset_i = OFFSET_WIDTH'($urandom);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
    end
    rst = 1'b0;
    bus.sync_req_i = 1'b0;
    bus.capture_i  = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
